// File: rtl/i2s_pkg.sv
// Shared I2S constants and types for the transmitter and receiver.
// No logic; compile-time only.
// Used by i2s_clkgen, i2s_tx and the PCM1808 receiver path.
package i2s_pkg;

    localparam int SLOT_BITS = 32;                  // bck periods per channel
    localparam int FS_DIV    = 256;                 // clk cycles per stereo frame
    localparam int BCK_DIV   = 4;                   // clk cycles per bck period

    localparam int P_W    = $clog2(FS_DIV);         // prescaler width
    localparam int SLOT_W = $clog2(SLOT_BITS);      // slot index width
    localparam int BCK_SH = $clog2(BCK_DIV);        // position of bck in prescaler

    typedef struct packed {
        logic [23:0] l;
        logic [23:0] r;
    } stereo_t;

endpackage

// File: rtl/i2s_clkgen.sv
// Free-running frame prescaler deriving bck, lrck and slot timing strobes.
// bck/lrck are prescaler bits, so they are registered with zero extra latency.
// No backpressure: runs continuously out of reset.
module i2s_clkgen
    import i2s_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    output logic              bck,
    output logic              lrck,
    output logic              bit_edge,   // next edge is bck falling: new slot starts
    output logic              lrck_nxt,
    output logic [SLOT_W-1:0] slot_nxt,
    output logic              pre_latch,  // p == FE
    output logic              latch       // p == FF, frame latch point
);

    logic [P_W-1:0] p;
    logic [P_W-1:0] p_nxt;

    assign p_nxt = p + P_W'(1);

    // Prescaler: one full wrap per stereo frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p <= '0;
        end else begin
            p <= p_nxt;
        end
    end

    assign bck       = p[BCK_SH-1];
    assign lrck      = p[P_W-1];
    assign bit_edge  = &p[BCK_SH-1:0];
    assign lrck_nxt  = p_nxt[P_W-1];
    assign slot_nxt  = p_nxt[P_W-2:BCK_SH];
    assign pre_latch = (p == P_W'(FS_DIV - 2));
    assign latch     = (p == P_W'(FS_DIV - 1));

endmodule

// File: rtl/i2s_tx.sv
// I2S master transmitter: one-entry holding buffer, frame latch, slot mux, underrun counter.
// A pair accepted with an empty buffer is sent in the frame after the next latch point.
// in_ready drops while the buffer holds a pair; it reopens the cycle after the latch.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int SAMPLE_W = 24,
    parameter int UCNT_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] in_left,
    input  logic [SAMPLE_W-1:0] in_right,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                scki,
    output logic                bck,
    output logic                lrck,
    output logic                sdata,
    output logic                frame_tick,
    output logic                underrun,
    output logic [UCNT_W-1:0]   ucount
);

    localparam logic [SLOT_W:0] LAST_SLOT = (SLOT_W+1)'(SAMPLE_W);

    logic                bit_edge;
    logic                lrck_nxt;
    logic [SLOT_W-1:0]   slot_nxt;
    logic                pre_latch;
    logic                latch;

    logic                buf_full;
    logic                buf_full_nxt;
    logic [SAMPLE_W-1:0] buf_l;
    logic [SAMPLE_W-1:0] buf_r;
    logic [SAMPLE_W-1:0] tx_l;
    logic [SAMPLE_W-1:0] tx_r;
    logic                xfer;
    logic                bit_nxt;

    i2s_clkgen u_clkgen (
        .clk       (clk),
        .reset     (reset),
        .bck       (bck),
        .lrck      (lrck),
        .bit_edge  (bit_edge),
        .lrck_nxt  (lrck_nxt),
        .slot_nxt  (slot_nxt),
        .pre_latch (pre_latch),
        .latch     (latch)
    );

    assign scki = clk;
    assign xfer = in_valid && in_ready;

    // Buffer occupancy after this edge. A latch only empties a full buffer and a
    // write only fills an empty one, so the two never collide.
    always_comb begin
        buf_full_nxt = buf_full;
        if (latch) begin
            buf_full_nxt = 1'b0;
        end
        if (xfer) begin
            buf_full_nxt = 1'b1;
        end
    end

    // Holding buffer and registered ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_full <= 1'b0;
            buf_l    <= '0;
            buf_r    <= '0;
            in_ready <= 1'b0;
        end else begin
            buf_full <= buf_full_nxt;
            in_ready <= !buf_full_nxt;
            if (xfer) begin
                buf_l <= in_left;
                buf_r <= in_right;
            end
        end
    end

    // Frame latch: move the buffered pair into the transmit registers, or silence.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_l <= '0;
            tx_r <= '0;
        end else if (latch) begin
            tx_l <= buf_full ? buf_l : '0;
            tx_r <= buf_full ? buf_r : '0;
        end
    end

    // Frame/underrun pulses are set one edge early so they are high during the
    // p == FF cycle. Buffer state entering that cycle is exactly what the latch sees.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_tick <= 1'b0;
            underrun   <= 1'b0;
            ucount     <= '0;
        end else begin
            frame_tick <= pre_latch;
            underrun   <= pre_latch && !buf_full_nxt;
            if (pre_latch && !buf_full_nxt && (ucount != '1)) begin
                ucount <= ucount + UCNT_W'(1);
            end
        end
    end

    // Slot mux: slot 0 is the I2S one-bit delay, then MSB first, then zero padding.
    always_comb begin
        logic [SAMPLE_W-1:0] word;
        logic [SAMPLE_W-1:0] shifted;
        logic                in_range;
        word     = lrck_nxt ? tx_r : tx_l;
        shifted  = word << (slot_nxt - SLOT_W'(1));
        in_range = (slot_nxt != '0) && ({1'b0, slot_nxt} <= LAST_SLOT);
        bit_nxt  = in_range && shifted[SAMPLE_W-1];
    end

    // Serial data updates only on the edge where bck falls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sdata <= 1'b0;
        end else if (bit_edge) begin
            sdata <= bit_nxt;
        end
    end

endmodule
